// File: rtl/ac_sequencer.sv
// Command sequencer for an address/accumulator register: walks a rows x cols tile,
// issuing clear/load/+1/+K pulses and presenting each element address under valid/ready.
module ac_sequencer #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] K     = 'd100
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] base_addr,
   input  logic [WIDTH-1:0] n_rows,
   input  logic [WIDTH-1:0] n_cols,
   input  logic             ready,
   output logic             ac_reset,
   output logic             ac_load,
   output logic             ac_inc,
   output logic             ac_inck,
   output logic [WIDTH-1:0] ac_data,
   output logic             addr_valid,
   output logic [WIDTH-1:0] addr_exp,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LD,
      S_WAIT,
      S_STEP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] inner_cnt_q, inner_cnt_d;
   logic [WIDTH-1:0] outer_cnt_q, outer_cnt_d;
   logic [WIDTH-1:0] inner_idx_q, inner_idx_d;
   logic [WIDTH-1:0] outer_idx_q, outer_idx_d;
   logic [WIDTH-1:0] outer_base_q, outer_base_d;
   logic [WIDTH-1:0] addr_exp_q, addr_exp_d;

   logic             last_inner;
   logic             last_outer;

   assign last_inner = (inner_idx_q == inner_cnt_q - ONE);
   assign last_outer = (outer_idx_q == outer_cnt_q - ONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         mode_q       <= 1'b0;
         inner_cnt_q  <= '0;
         outer_cnt_q  <= '0;
         inner_idx_q  <= '0;
         outer_idx_q  <= '0;
         outer_base_q <= '0;
         addr_exp_q   <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         inner_cnt_q  <= inner_cnt_d;
         outer_cnt_q  <= outer_cnt_d;
         inner_idx_q  <= inner_idx_d;
         outer_idx_q  <= outer_idx_d;
         outer_base_q <= outer_base_d;
         addr_exp_q   <= addr_exp_d;
      end
   end

   // addr_exp_q mirrors the register's next-state function for each issued command.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      inner_cnt_d  = inner_cnt_q;
      outer_cnt_d  = outer_cnt_q;
      inner_idx_d  = inner_idx_q;
      outer_idx_d  = outer_idx_q;
      outer_base_d = outer_base_q;
      addr_exp_d   = addr_exp_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d       = mode;
               inner_cnt_d  = mode ? n_cols : n_rows;
               outer_cnt_d  = mode ? n_rows : n_cols;
               inner_idx_d  = '0;
               outer_idx_d  = '0;
               outer_base_d = base_addr;
               state_d      = ((n_rows == '0) || (n_cols == '0)) ? S_DONE : S_CLR;
            end
         end
         S_CLR: begin
            addr_exp_d = '0;
            state_d    = S_LD;
         end
         S_LD: begin
            addr_exp_d  = outer_base_q;
            inner_idx_d = '0;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            if (ready) begin
               if (last_inner && last_outer) begin
                  state_d = S_DONE;
               end else if (last_inner) begin
                  outer_idx_d  = outer_idx_q + ONE;
                  outer_base_d = outer_base_q + (mode_q ? K : ONE);
                  state_d      = S_LD;
               end else begin
                  inner_idx_d = inner_idx_q + ONE;
                  state_d     = S_STEP;
               end
            end
         end
         S_STEP: begin
            addr_exp_d = addr_exp_q + (mode_q ? ONE : K);
            state_d    = S_WAIT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      ac_reset   = (state_q == S_CLR);
      ac_load    = (state_q == S_LD);
      ac_inc     = (state_q == S_STEP) && mode_q;
      ac_inck    = (state_q == S_STEP) && !mode_q;
      addr_valid = (state_q == S_WAIT);
      busy       = (state_q == S_CLR) || (state_q == S_LD) ||
                   (state_q == S_WAIT) || (state_q == S_STEP);
      done       = (state_q == S_DONE);
   end

   assign ac_data  = outer_base_q;
   assign addr_exp = addr_exp_q;

endmodule

// File: tb/tb_ac_sequencer.sv
// Self-checking bench for ac_sequencer: directed and randomized tile walks compared
// against a matrix-indexing reference model of commands, load values and addresses.
module tb_ac_sequencer;

   localparam logic [15:0] KV = 16'd100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        mode;
   logic [15:0] base_addr;
   logic [15:0] n_rows;
   logic [15:0] n_cols;
   logic        ready;
   logic        ac_reset;
   logic        ac_load;
   logic        ac_inc;
   logic        ac_inck;
   logic [15:0] ac_data;
   logic        addr_valid;
   logic [15:0] addr_exp;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   ac_sequencer #(.WIDTH(16), .K(KV)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .mode       (mode),
      .base_addr  (base_addr),
      .n_rows     (n_rows),
      .n_cols     (n_cols),
      .ready      (ready),
      .ac_reset   (ac_reset),
      .ac_load    (ac_load),
      .ac_inc     (ac_inc),
      .ac_inck    (ac_inck),
      .ac_data    (ac_data),
      .addr_valid (addr_valid),
      .addr_exp   (addr_exp),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ac_reset"}, {31'd0, ac_reset}, 32'd0);
      chk({tag, "_ac_load"},  {31'd0, ac_load},  32'd0);
      chk({tag, "_ac_inc"},   {31'd0, ac_inc},   32'd0);
      chk({tag, "_ac_inck"},  {31'd0, ac_inck},  32'd0);
      chk({tag, "_ac_data"},  {16'd0, ac_data},  32'd0);
      chk({tag, "_valid"},    {31'd0, addr_valid}, 32'd0);
      chk({tag, "_addr_exp"}, {16'd0, addr_exp}, 32'd0);
      chk({tag, "_busy"},     {31'd0, busy},     32'd0);
      chk({tag, "_done"},     {31'd0, done},     32'd0);
   endtask

   // Element (r,c) lives at base + r*K + c; column-major walks rows fastest.
   function automatic logic [15:0] elem(input logic [15:0] b, input int r, input int c);
      logic [31:0] full;
      full = 32'(b) + 32'(r) * 32'(KV) + 32'(c);
      return full[15:0];
   endfunction

   // rdy_mode: 0 = ready tied high, 1 = random, 2 = 3-cycle stall on the second element
   task automatic run_walk(input string name, input logic m, input logic [15:0] b,
                           input int rows, input int cols, input int rdy_mode, input bit inject);
      logic [7:0]  cmd_q[$];
      logic [15:0] ld_q[$];
      logic [15:0] adr_q[$];
      int inner, outer, budget, nact, popped, stall, last_hs, first_valid;
      bit done_seen, wait_next;
      logic [7:0] got, e;

      inner = m ? cols : rows;
      outer = m ? rows : cols;
      if (rows != 0 && cols != 0) begin
         cmd_q.push_back("R");
         for (int o = 0; o < outer; o++) begin
            cmd_q.push_back("L");
            ld_q.push_back(m ? elem(b, o, 0) : elem(b, 0, o));
            for (int i = 0; i < inner; i++) begin
               if (i > 0) cmd_q.push_back(m ? 8'("I") : 8'("K"));
               adr_q.push_back(m ? elem(b, o, i) : elem(b, i, o));
            end
         end
      end
      budget = 20 * rows * cols + 20;

      start = 1'b1; mode = m; base_addr = b;
      n_rows = 16'(rows); n_cols = 16'(cols); ready = 1'b0;
      tick();
      start = 1'b0;
      done_seen = 1'b0; popped = 0; stall = 0; last_hs = 0; wait_next = 1'b0;
      first_valid = -1;

      for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
         nact = int'(ac_reset) + int'(ac_load) + int'(ac_inc) + int'(ac_inck);
         chk({name, "_onehot"}, 32'(nact <= 1), 32'd1);
         chk({name, "_busy"}, {31'd0, busy}, {31'd0, !done});
         if (addr_valid) chk({name, "_cmd_in_wait"}, 32'(nact), 32'd0);
         if (nact == 1) begin
            got = ac_reset ? 8'("R") : ac_load ? 8'("L") : ac_inc ? 8'("I") : 8'("K");
            if (cmd_q.size() == 0) begin
               chk({name, "_extra_cmd"}, 32'(got), 32'd0);
            end else begin
               e = cmd_q.pop_front();
               chk({name, "_cmd"}, 32'(got), 32'(e));
               if (e == "L" && ld_q.size() > 0) chk({name, "_ac_data"}, 32'(ac_data), 32'(ld_q.pop_front()));
            end
         end
         if (addr_valid) begin
            if (first_valid < 0) begin
               first_valid = cyc;
               chk({name, "_first_lat"}, 32'(cyc), 32'd2);
            end
            if (wait_next) begin
               chk({name, "_hs_gap"}, 32'(cyc - last_hs), 32'd2);
               wait_next = 1'b0;
            end
            if (adr_q.size() == 0) chk({name, "_extra_valid"}, 32'd1, 32'd0);
            else chk({name, "_addr"}, 32'(addr_exp), 32'(adr_q[0]));
         end
         if (done) begin
            done_seen = 1'b1;
            start = 1'b0;
            chk({name, "_cmds_left"}, 32'(cmd_q.size()), 32'd0);
            chk({name, "_addrs_left"}, 32'(adr_q.size()), 32'd0);
         end else begin
            case (rdy_mode)
               0: ready = 1'b1;
               1: ready = 1'($urandom_range(0, 1));
               default: begin
                  if (addr_valid && popped == 1 && stall < 3) begin
                     ready = 1'b0;
                     stall++;
                  end else ready = 1'b1;
               end
            endcase
            if (addr_valid && ready && adr_q.size() > 0) begin
               void'(adr_q.pop_front());
               popped++;
               last_hs = cyc;
               wait_next = (adr_q.size() > 0);
            end
            start = inject ? 1'($urandom_range(0, 1)) : 1'b0;
            mode = 1'($urandom_range(0, 1));
            base_addr = 16'($urandom);
            n_rows = 16'($urandom_range(0, 5));
            n_cols = 16'($urandom_range(0, 5));
            tick();
         end
      end
      chk({name, "_done_seen"}, {31'd0, done_seen}, 32'd1);
      if (rows != 0 && cols != 0) chk({name, "_saw_valid"}, 32'(first_valid >= 0), 32'd1);
      if (rdy_mode == 2) chk({name, "_stall_len"}, 32'(stall), 32'd3);
      ready = 1'b0;
      tick();
      chk({name, "_idle_done"}, {31'd0, done}, 32'd0);
      chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_idle_valid"}, {31'd0, addr_valid}, 32'd0);
      $display("walk %s mode=%0d base=%h rows=%0d cols=%0d checks=%0d failures=%0d",
               name, m, b, rows, cols, checks, failures);
   endtask

   initial begin
      bit found;
      reset_n = 1'b0; start = 1'b0; mode = 1'b0; ready = 1'b0;
      base_addr = '0; n_rows = '0; n_cols = '0;
      tick();
      tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();
      check_all_zero("post_reset");

      run_walk("colmajor", 1'b0, 16'h0000, 2, 3, 0, 1'b0);
      run_walk("rowmajor", 1'b1, 16'h0000, 2, 3, 0, 1'b0);
      run_walk("stall",    1'b0, 16'h0000, 2, 3, 2, 1'b0);
      run_walk("zero_row", 1'b0, 16'h1234, 0, 3, 0, 1'b0);
      run_walk("zero_col", 1'b1, 16'h1234, 2, 0, 0, 1'b0);
      run_walk("wrap",     1'b1, 16'hFFFF, 1, 2, 0, 1'b0);

      // Abort a walk while a +K step is being issued.
      start = 1'b1; mode = 1'b0; base_addr = 16'h0040; n_rows = 16'd2; n_cols = 16'd3;
      tick();
      start = 1'b0; ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (ac_inck) found = 1'b1;
         else tick();
      end
      chk("abort_reached_step", {31'd0, found}, 32'd1);
      #1 reset_n = 1'b0;
      #1 check_all_zero("abort_async");
      tick();
      check_all_zero("abort_held");
      ready = 1'b0;
      reset_n = 1'b1;
      tick();
      check_all_zero("abort_released");
      run_walk("after_abort", 1'b1, 16'h0005, 2, 2, 0, 1'b0);

      run_walk("start_busy", 1'b0, 16'h0000, 2, 3, 0, 1'b1);

      for (int n = 0; n < 12; n++) begin
         run_walk("random", 1'($urandom_range(0, 1)), 16'($urandom),
                  (n % 6 == 5) ? 0 : int'($urandom_range(1, 4)),
                  int'($urandom_range(1, 4)), 1, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
